spi_mult_ctrl: RTL and testbench

SPI-slave front-end controller that sequences an external multi-cycle multiplier for the serial multiply peripheral. It deserialises two WIDTH-bit operands from MOSI, launches the multiplier, waits a fixed gap of SCLK cycles, then serialises the 2*WIDTH-bit product on MISO, MSB first. It runs in the system CLK domain and oversamples the asynchronous SPI pins.

---
 rtl/spi_mult_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_spi_mult_ctrl.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/spi_mult_ctrl.sv
// SPI-slave front end for a serial multiply peripheral: receives A then B, launches an
// external multiplier, and returns the 2*WIDTH-bit product on MISO after a fixed SCLK gap.
// state   | meaning
// IDLE    | waiting for CS rising edge
// RX      | shifting operands in; launches multiplier after last operand bit
// MUL     | waiting for mul_done or the deadline falling edge
// GAP     | product captured, holding MISO low until the first TX bit
// TX      | driving product bits on SCLK falling edges
// HOLD    | frame complete, ignoring SCLK until CS falls
// DRAIN   | frame aborted with multiplier in flight; discarding its product
module spi_mult_ctrl #(
  parameter int WIDTH       = 4,
  parameter int GAP         = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_sclk,
  input  logic               i_cs,
  input  logic               i_mosi,
  output logic               o_miso,
  output logic               o_mul_start,
  output logic [WIDTH-1:0]   o_mul_a,
  output logic [WIDTH-1:0]   o_mul_b,
  input  logic               i_mul_done,
  input  logic [2*WIDTH-1:0] i_mul_p,
  output logic               o_busy,
  output logic               o_late
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(4 * WIDTH + GAP + 1);
  localparam logic [CW-1:0] C_LAST_RX  = CW'(PW - 1);
  localparam logic [CW-1:0] C_DEADLINE = CW'(PW + GAP);
  localparam logic [CW-1:0] C_TX_END   = CW'(2 * PW + GAP);

  typedef enum logic [2:0] {
    S_IDLE, S_RX, S_MUL, S_GAP, S_TX, S_HOLD, S_DRAIN
  } state_t;

  state_t r_state, w_state_nxt;

  logic [SYNC_STAGES-1:0] r_sclk_sync, r_cs_sync, r_mosi_sync;
  logic [SYNC_STAGES:0]   r_arm;
  logic                   r_sclk_prev, r_cs_prev;
  logic                   r_sclk_rise, r_sclk_fall, r_cs_rise, r_cs_fall, r_mosi_s;
  logic [CW-1:0]          r_bit_cnt;
  logic [PW-1:0]          r_rx_sh, r_tx_sh;
  logic [PW-1:0]          w_rx_shift;
  logic [WIDTH-1:0]       r_mul_a, r_mul_b;
  logic                   r_mul_start, r_miso, r_late;
  logic                   w_deadline, w_tx_end;

  // Edge pulses are suppressed until the synchroniser has filled after reset, so a CS
  // already high at reset release is not mistaken for a new frame.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sclk_sync <= '0;
      r_cs_sync   <= '0;
      r_mosi_sync <= '0;
      r_arm       <= '0;
      r_sclk_prev <= 1'b0;
      r_cs_prev   <= 1'b0;
      r_sclk_rise <= 1'b0;
      r_sclk_fall <= 1'b0;
      r_cs_rise   <= 1'b0;
      r_cs_fall   <= 1'b0;
      r_mosi_s    <= 1'b0;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], i_sclk};
      r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], i_cs};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], i_mosi};
      r_arm       <= {r_arm[SYNC_STAGES-1:0], 1'b1};
      r_sclk_prev <= r_sclk_sync[SYNC_STAGES-1];
      r_cs_prev   <= r_cs_sync[SYNC_STAGES-1];
      r_sclk_rise <= r_arm[SYNC_STAGES] &  r_sclk_sync[SYNC_STAGES-1] & ~r_sclk_prev;
      r_sclk_fall <= r_arm[SYNC_STAGES] & ~r_sclk_sync[SYNC_STAGES-1] &  r_sclk_prev;
      r_cs_rise   <= r_arm[SYNC_STAGES] &  r_cs_sync[SYNC_STAGES-1] & ~r_cs_prev;
      r_cs_fall   <= r_arm[SYNC_STAGES] & ~r_cs_sync[SYNC_STAGES-1] &  r_cs_prev;
      r_mosi_s    <= r_mosi_sync[SYNC_STAGES-1];
    end
  end

  assign w_rx_shift = {r_rx_sh[PW-2:0], r_mosi_s};
  assign w_deadline = r_sclk_fall && (r_bit_cnt == C_DEADLINE);
  assign w_tx_end   = r_sclk_fall && (r_bit_cnt == C_TX_END);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // CS falling edge is checked first everywhere so it beats any same-cycle SCLK edge.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (r_cs_rise) w_state_nxt = S_RX;
      S_RX: begin
        if (r_mul_start)    w_state_nxt = r_cs_fall ? S_DRAIN : S_MUL;
        else if (r_cs_fall) w_state_nxt = S_IDLE;
      end
      S_MUL: begin
        if (r_cs_fall)       w_state_nxt = S_DRAIN;
        else if (w_deadline) w_state_nxt = S_TX;
        else if (i_mul_done) w_state_nxt = S_GAP;
      end
      S_GAP: begin
        if (r_cs_fall)       w_state_nxt = S_IDLE;
        else if (w_deadline) w_state_nxt = S_TX;
      end
      S_TX: begin
        if (r_cs_fall)     w_state_nxt = S_IDLE;
        else if (w_tx_end) w_state_nxt = S_HOLD;
      end
      S_HOLD:  if (r_cs_fall) w_state_nxt = S_IDLE;
      S_DRAIN: if (i_mul_done) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_bit_cnt   <= '0;
      r_rx_sh     <= '0;
      r_tx_sh     <= '0;
      r_mul_a     <= '0;
      r_mul_b     <= '0;
      r_mul_start <= 1'b0;
      r_miso      <= 1'b0;
      r_late      <= 1'b0;
    end else begin
      r_mul_start <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_miso <= 1'b0;
          if (r_cs_rise) begin
            r_bit_cnt <= '0;
            r_rx_sh   <= '0;
            r_late    <= 1'b0;
          end
        end
        S_RX: begin
          r_miso <= 1'b0;
          if (r_sclk_rise && !r_cs_fall && !r_mul_start) begin
            r_bit_cnt <= r_bit_cnt + 1'b1;
            r_rx_sh   <= w_rx_shift;
            if (r_bit_cnt == C_LAST_RX) begin
              r_mul_a     <= w_rx_shift[PW-1:WIDTH];
              r_mul_b     <= w_rx_shift[WIDTH-1:0];
              r_mul_start <= 1'b1;
            end
          end
        end
        S_MUL: begin
          r_miso <= 1'b0;
          if (r_sclk_rise) r_bit_cnt <= r_bit_cnt + 1'b1;
          if (!r_cs_fall) begin
            if (w_deadline) begin
              r_late  <= 1'b1;
              r_tx_sh <= '0;
            end else if (i_mul_done) begin
              r_tx_sh <= i_mul_p;
            end
          end
        end
        S_GAP: begin
          if (r_sclk_rise) r_bit_cnt <= r_bit_cnt + 1'b1;
          if (!r_cs_fall && w_deadline) begin
            r_miso  <= r_tx_sh[PW-1];
            r_tx_sh <= {r_tx_sh[PW-2:0], 1'b0};
          end else begin
            r_miso <= 1'b0;
          end
        end
        S_TX: begin
          if (r_sclk_rise) r_bit_cnt <= r_bit_cnt + 1'b1;
          if (r_cs_fall || w_tx_end) begin
            r_miso <= 1'b0;
          end else if (r_sclk_fall) begin
            r_miso  <= r_tx_sh[PW-1];
            r_tx_sh <= {r_tx_sh[PW-2:0], 1'b0};
          end
        end
        default: r_miso <= 1'b0;
      endcase
    end
  end

  assign o_miso      = r_miso;
  assign o_mul_start = r_mul_start;
  assign o_mul_a     = r_mul_a;
  assign o_mul_b     = r_mul_b;
  assign o_late      = r_late;
  assign o_busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_spi_mult_ctrl.sv
// Directed bench for spi_mult_ctrl: SPI master, behavioural multiplier with programmable
// latency, and hand-computed product/flag expectations.
module tb_spi_mult_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sclk = 1'b0;
  logic       cs = 1'b0;
  logic       mosi = 1'b0;
  logic       mul_done = 1'b0;
  logic [7:0] mul_p = 8'h00;
  logic       miso, mul_start, busy, late;
  logic [3:0] mul_a, mul_b;

  int          checks = 0;
  int          errors = 0;
  int          start_cnt = 0;
  int          mul_lat = 5;
  int          pend = 0;
  int          s0;
  logic [3:0]  seen_a = 4'h0, seen_b = 4'h0;
  logic [31:0] miso_at;
  logic        b3, b4;

  spi_mult_ctrl #(.WIDTH(4), .GAP(4), .SYNC_STAGES(2)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_sclk(sclk), .i_cs(cs), .i_mosi(mosi),
    .o_miso(miso), .o_mul_start(mul_start), .o_mul_a(mul_a), .o_mul_b(mul_b),
    .i_mul_done(mul_done), .i_mul_p(mul_p), .o_busy(busy), .o_late(late)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Behavioural multiplier: done pulses mul_lat CLKs after start.
  initial begin
    forever begin
      @(negedge clk);
      mul_done = 1'b0;
      if (mul_start) begin
        start_cnt++;
        seen_a = mul_a;
        seen_b = mul_b;
        pend   = mul_lat;
      end else if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          mul_done = 1'b1;
          mul_p    = {4'h0, seen_a} * {4'h0, seen_b};
        end
      end
    end
  end

  function automatic logic [7:0] tx_bits();
    logic [7:0] p;
    for (int k = 0; k < 8; k++) p[7-k] = miso_at[13+k];
    return p;
  endfunction

  // One frame of n_rise SCLK cycles (20 CLK period); optional reset pulse after rise rst_at.
  task automatic frame(input logic [3:0] a, input logic [3:0] b, input int n_rise,
                       input int rst_at);
    logic [7:0] ops;
    ops = {a, b};
    miso_at = '0;
    @(negedge clk);
    cs = 1'b1;
    repeat (10) @(negedge clk);
    for (int i = 1; i <= n_rise; i++) begin
      mosi = (i <= 8) ? ops[8-i] : 1'b0;
      repeat (10) @(negedge clk);
      miso_at[i] = miso;
      sclk = 1'b1;
      repeat (10) @(negedge clk);
      sclk = 1'b0;
      if (i == rst_at) begin
        repeat (6) @(negedge clk);
        check("rst_pre_miso", {31'b0, miso}, 32'd1);
        check("rst_pre_busy", {31'b0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst_outputs", {28'b0, miso, mul_start, busy, late}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
      end
    end
    repeat (10) @(negedge clk);
  endtask

  task automatic cs_drop(output logic busy3, output logic busy4);
    cs = 1'b0;
    repeat (3) @(negedge clk);
    busy3 = busy;
    @(negedge clk);
    busy4 = busy;
    repeat (10) @(negedge clk);
  endtask

  initial begin
    repeat (5) @(negedge clk);
    check("reset_vals", {20'b0, miso, mul_start, mul_a, mul_b, busy, late}, 32'd0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // 0001 x 0110
    s0 = start_cnt;
    frame(4'h1, 4'h6, 20, 0);
    check("t1_starts", start_cnt - s0, 32'd1);
    check("t1_mul_a", {28'b0, seen_a}, 32'd1);
    check("t1_mul_b", {28'b0, seen_b}, 32'd6);
    check("t1_gap_miso", {28'b0, miso_at[12:9]}, 32'd0);
    check("t1_product", {24'b0, tx_bits()}, 32'h06);
    check("t1_late", {31'b0, late}, 32'd0);
    check("t1_hold_busy", {31'b0, busy}, 32'd1);
    cs_drop(b3, b4);
    check("t1_busy_det", {31'b0, b3}, 32'd1);
    check("t1_busy_fall", {31'b0, b4}, 32'd0);

    // 1111 x 1111
    frame(4'hF, 4'hF, 20, 0);
    check("t2_product", {24'b0, tx_bits()}, 32'hE1);
    cs_drop(b3, b4);

    // deadline miss, then recovery
    mul_lat = 100;
    s0 = start_cnt;
    frame(4'h2, 4'h7, 20, 0);
    check("t3_starts", start_cnt - s0, 32'd1);
    check("t3_late", {31'b0, late}, 32'd1);
    check("t3_tx_zero", {24'b0, tx_bits()}, 32'h00);
    check("t3_late_miso", {31'b0, miso}, 32'd0);
    cs_drop(b3, b4);
    check("t3_late_kept", {31'b0, late}, 32'd1);
    mul_lat = 5;
    frame(4'h2, 4'h7, 20, 0);
    check("t3_recover_late", {31'b0, late}, 32'd0);
    check("t3_recover_prod", {24'b0, tx_bits()}, 32'h0E);
    cs_drop(b3, b4);

    // abort after rise 5
    s0 = start_cnt;
    frame(4'h3, 4'h3, 5, 0);
    cs_drop(b3, b4);
    check("t4_abort_starts", start_cnt - s0, 32'd0);
    check("t4_abort_busy", {31'b0, b4}, 32'd0);
    check("t4_abort_miso", {31'b0, miso}, 32'd0);

    // abort inside MUL -> DRAIN
    mul_lat = 60;
    s0 = start_cnt;
    frame(4'h3, 4'h3, 8, 0);
    cs = 1'b0;
    repeat (10) @(negedge clk);
    check("t4_drain_busy", {31'b0, busy}, 32'd1);
    check("t4_drain_miso", {31'b0, miso}, 32'd0);
    repeat (70) @(negedge clk);
    check("t4_drain_idle", {31'b0, busy}, 32'd0);
    check("t4_drain_starts", start_cnt - s0, 32'd1);
    mul_lat = 5;
    frame(4'h3, 4'h3, 20, 0);
    check("t4_after_prod", {24'b0, tx_bits()}, 32'h09);
    cs_drop(b3, b4);

    // reset during TX
    frame(4'hF, 4'hF, 20, 14);
    check("t5_post_miso", {26'b0, miso_at[20:15]}, 32'd0);
    check("t5_post_busy", {31'b0, busy}, 32'd1 - 32'd1);
    check("t5_post_late", {31'b0, late}, 32'd0);
    cs_drop(b3, b4);

    // extra SCLK cycles in HOLD
    s0 = start_cnt;
    frame(4'h5, 4'h3, 24, 0);
    check("t6_product", {24'b0, tx_bits()}, 32'h0F);
    check("t6_extra_miso", {28'b0, miso_at[24:21]}, 32'd0);
    check("t6_starts", start_cnt - s0, 32'd1);
    check("t6_hold_busy", {31'b0, busy}, 32'd1);
    cs_drop(b3, b4);
    check("t6_idle", {31'b0, b4}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
